// File: rtl/seq_timer_pkg.sv
// Shared definitions for the seq_timer command-port responder: command
// codes, FSM state encoding, readback selects and status bit positions.
package seq_timer_pkg;

   localparam logic [3:0] SeqTimer_NOP = 4'h0;
   localparam logic [3:0] SeqTimer_LDV = 4'h1;
   localparam logic [3:0] SeqTimer_STR = 4'h2;
   localparam logic [3:0] SeqTimer_STP = 4'h3;
   localparam logic [3:0] SeqTimer_ACK = 4'h4;
   localparam logic [3:0] SeqTimer_SEL = 4'h5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'h0,
      ST_RUN  = 2'h1,
      ST_DONE = 2'h2
   } state_t;

   localparam logic [1:0] RSEL_COUNT  = 2'd0;
   localparam logic [1:0] RSEL_RELOAD = 2'd1;
   localparam logic [1:0] RSEL_STATUS = 2'd2;
   localparam logic [1:0] RSEL_ID     = 2'd3;

   localparam int STAT_DONE = 0;
   localparam int STAT_RUN  = 1;
   localparam int STAT_ERR  = 7;

endpackage

// File: rtl/seq_timer_if.sv
// Sequencer output-lane bus to the timer: command word and write enable in,
// readback and done flag out.
interface seq_timer_if;
   logic [11:0] cmd_word;
   logic        cmd_en;
   logic [7:0]  rdata;
   logic        done;

   modport master (output cmd_word, output cmd_en, input rdata, input done);
   modport slave  (input cmd_word, input cmd_en, output rdata, output done);
endinterface

// File: rtl/seq_timer_prescaler.sv
// Free-running 0..PRESCALE-1 counter gated by enable; tick marks the wrap
// cycle. clear restarts the phase so a fresh start gets a full first period.
module seq_timer_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next phase: clear wins, otherwise advance and wrap while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   // phase register
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/seq_timer.sv
// Prescaled 8-bit down-counter timer polled by the sequencer through a
// selectable readback. Optional macro SEQ_TIMER_AUTORELOAD_EN makes the timer
// reload and keep running at terminal count instead of stopping in DONE.
//
// state | meaning
// IDLE  | counter held
// RUN   | counting down one per prescaler tick
// DONE  | terminal count reached, count held at 0
module seq_timer #(
   parameter int          PRESCALE = 4,
   parameter logic [7:0]  TIMER_ID = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   seq_timer_if.slave bus
);
   import seq_timer_pkg::*;

   logic [3:0] cmd_code;
   logic [7:0] cmd_data;
   state_t     state_q;
   logic [7:0] count_q;
   logic [7:0] reload_q;
   logic [1:0] rsel_q;
   logic       done_q;
   logic       err_q;
   logic       tick;
   logic       term_tick;
   logic       str_cmd;
   logic [7:0] status;

   assign cmd_code  = bus.cmd_word[11:8];
   assign cmd_data  = bus.cmd_word[7:0];
   assign str_cmd   = bus.cmd_en && (cmd_code == SeqTimer_STR);
   assign term_tick = (state_q == ST_RUN) && tick && (count_q <= 8'd1);

   seq_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .enable (state_q == ST_RUN),
      .clear  (str_cmd),
      .tick   (tick)
   );

   // timer FSM: tick effects first, then any accepted command overrides them
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= 8'h00;
         reload_q <= 8'h00;
         rsel_q   <= RSEL_COUNT;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == ST_RUN && tick) begin
            if (count_q <= 8'd1) begin
               done_q <= 1'b1;
`ifdef SEQ_TIMER_AUTORELOAD_EN
               if (reload_q != 8'h00) begin
                  count_q <= reload_q;
               end else begin
                  count_q <= 8'h00;
                  state_q <= ST_DONE;
               end
`else
               count_q <= 8'h00;
               state_q <= ST_DONE;
`endif
            end else begin
               count_q <= count_q - 8'd1;
            end
         end

         if (bus.cmd_en) begin
            case (cmd_code)
               SeqTimer_NOP: ;
               SeqTimer_LDV: reload_q <= cmd_data;
               SeqTimer_STR: begin
                  if (reload_q == 8'h00) begin
                     count_q <= 8'h00;
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     count_q <= reload_q;
                     state_q <= ST_RUN;
                     done_q  <= done_q;
                  end
               end
               SeqTimer_STP: begin
                  if (state_q == ST_RUN) begin
                     state_q <= ST_IDLE;
                     count_q <= count_q;
                     done_q  <= done_q;
                  end
               end
               SeqTimer_ACK: begin
                  // a terminal tick in the same cycle keeps the flag set
                  if (!term_tick) begin
                     done_q <= 1'b0;
                  end
                  if (state_q == ST_DONE) begin
                     state_q <= ST_IDLE;
                  end
               end
               SeqTimer_SEL: rsel_q <= cmd_data[1:0];
               default:      err_q  <= 1'b1;
            endcase
         end
      end
   end

   // readback mux over registered state
   always_comb begin
      status            = 8'h00;
      status[STAT_DONE] = done_q;
      status[STAT_RUN]  = (state_q == ST_RUN);
      status[STAT_ERR]  = err_q;
      case (rsel_q)
         RSEL_COUNT:  bus.rdata = count_q;
         RSEL_RELOAD: bus.rdata = reload_q;
         RSEL_STATUS: bus.rdata = status;
         default:     bus.rdata = TIMER_ID;
      endcase
   end

   assign bus.done = done_q;

endmodule

// File: tb/tb_seq_timer.sv
// Self-checking bench for seq_timer: directed scenarios against fixed
// expectations plus randomized commands against a cycle-arithmetic model.
module tb_seq_timer;

   localparam int P = 4;
`ifdef SEQ_TIMER_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   seq_timer_if bus_if ();

   seq_timer #(.PRESCALE(P), .TIMER_ID(8'hA5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model: a running timer is described by the number of cycles
   // left until terminal count; the visible count is that figure divided by
   // the prescale, rounded up
   int         m_mode;   // 0 idle, 1 run, 2 done
   int         m_rem;
   int         m_held;
   int         m_reload;
   int         m_rsel;
   bit         m_done;
   bit         m_err;

   function automatic int m_count();
      return (m_mode == 1) ? (m_rem + P - 1) / P : m_held;
   endfunction

   function automatic logic [7:0] m_rdata();
      case (m_rsel)
         0: return 8'(m_count());
         1: return 8'(m_reload);
         2: return {m_err, 5'b0, (m_mode == 1), m_done};
         default: return 8'hA5;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_rem = 0; m_held = 0; m_reload = 0;
      m_rsel = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step(input logic en, input logic [11:0] w);
      int mode_n, rem_n, held_n, reload_n, rsel_n;
      bit done_n, err_n, term;
      int code, data, shown;
      code = int'(w[11:8]);
      data = int'(w[7:0]);
      term = (m_mode == 1) && (m_rem == 1);
      shown = m_count();
      mode_n = m_mode; rem_n = m_rem; held_n = m_held; reload_n = m_reload;
      rsel_n = m_rsel; done_n = m_done; err_n = m_err;
      if (m_mode == 1) begin
         rem_n = m_rem - 1;
         if (term) begin
            done_n = 1;
            if (AR && m_reload != 0) rem_n = m_reload * P;
            else begin mode_n = 2; held_n = 0; end
         end
      end
      if (en) begin
         case (code)
            0: ;
            1: reload_n = data;
            2: begin
               mode_n = m_mode; held_n = m_held; done_n = m_done;
               if (m_reload == 0) begin mode_n = 2; held_n = 0; done_n = 1; end
               else begin mode_n = 1; rem_n = m_reload * P; end
            end
            3: if (m_mode == 1) begin
               mode_n = 0; held_n = shown; done_n = m_done; rem_n = m_rem;
            end
            4: begin
               if (!term) done_n = 0;
               if (m_mode == 2) mode_n = 0;
            end
            5: rsel_n = data % 4;
            default: err_n = 1;
         endcase
      end
      m_mode = mode_n; m_rem = rem_n; m_held = held_n; m_reload = reload_n;
      m_rsel = rsel_n; m_done = done_n; m_err = err_n;
   endtask

   // one clock with the given bus inputs; outputs are sampled 1 ns after the edge
   task automatic cyc(input logic en, input logic [11:0] w);
      bus_if.cmd_en   = en;
      bus_if.cmd_word = w;
      @(posedge clock);
      model_step(en, w);
      #1;
      bus_if.cmd_en   = 1'b0;
      bus_if.cmd_word = 12'h000;
   endtask

   task automatic cmd(input logic [3:0] code, input logic [7:0] data);
      cyc(1'b1, {code, data});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 12'h000);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clock);
      model_reset();
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      cmd(4'h5, 8'h00);
      cmd(4'h1, 8'h0A);
      cmd(4'h2, 8'h00);
      idle(5);
      apply_reset(2);
      n_checks++;
      if (bus_if.rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", bus_if.rdata);
      else n_pass++;
      n_checks++;
      if (bus_if.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus_if.done);
      else n_pass++;
      cmd(4'h5, 8'h02);
      n_checks++;
      if (bus_if.rdata !== 8'h00) $display("FAIL reset_status: got %h expected 00", bus_if.rdata);
      else n_pass++;
      cmd(4'h5, 8'h01);
      n_checks++;
      if (bus_if.rdata !== 8'h00) $display("FAIL reset_reload: got %h expected 00", bus_if.rdata);
      else n_pass++;
   endtask

   task automatic test_basic_run();
      cmd(4'h5, 8'h00);
      cmd(4'h1, 8'h03);
      cmd(4'h2, 8'h00);
      for (int k = 1; k <= 12; k++) begin
         idle(1);
         if (k == 11) begin
            n_checks++;
            if (bus_if.done !== 1'b0 || bus_if.rdata !== 8'h01)
               $display("FAIL run_before_tc: got done=%b count=%h expected done=0 count=01", bus_if.done, bus_if.rdata);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus_if.done !== 1'b1) $display("FAIL run_done_at_12: got %b expected 1", bus_if.done);
      else n_pass++;
      n_checks++;
      if (bus_if.rdata !== (AR ? 8'h03 : 8'h00))
         $display("FAIL run_count_at_tc: got %h expected %h", bus_if.rdata, AR ? 8'h03 : 8'h00);
      else n_pass++;
      cmd(4'h5, 8'h02);
      n_checks++;
      if (bus_if.rdata !== (AR ? 8'h03 : 8'h01))
         $display("FAIL run_status_done: got %h expected %h", bus_if.rdata, AR ? 8'h03 : 8'h01);
      else n_pass++;
      cmd(4'h4, 8'h00);
      n_checks++;
      if (bus_if.rdata !== (AR ? 8'h02 : 8'h00))
         $display("FAIL run_status_ack: got %h expected %h", bus_if.rdata, AR ? 8'h02 : 8'h00);
      else n_pass++;
      cmd(4'h3, 8'h00);
   endtask

   task automatic test_stop_boundary();
      cmd(4'h5, 8'h00);
      cmd(4'h1, 8'h05);
      cmd(4'h2, 8'h00);
      idle(8);
      cmd(4'h3, 8'h00);
      n_checks++;
      if (bus_if.rdata !== 8'h03) $display("FAIL stop_count: got %h expected 03", bus_if.rdata);
      else n_pass++;
      idle(6);
      n_checks++;
      if (bus_if.rdata !== 8'h03 || bus_if.done !== 1'b0)
         $display("FAIL stop_hold: got count=%h done=%b expected count=03 done=0", bus_if.rdata, bus_if.done);
      else n_pass++;
      cmd(4'h1, 8'h00);
      cmd(4'h2, 8'h00);
      n_checks++;
      if (bus_if.done !== 1'b1 || bus_if.rdata !== 8'h00)
         $display("FAIL str_zero: got done=%b count=%h expected done=1 count=00", bus_if.done, bus_if.rdata);
      else n_pass++;
      cmd(4'h4, 8'h00);
   endtask

   task automatic test_simultaneous();
      cmd(4'h5, 8'h00);
      cmd(4'h1, 8'h01);
      cmd(4'h2, 8'h00);
      idle(P - 1);
      cmd(4'h3, 8'h00);
      n_checks++;
      if (bus_if.done !== 1'b0 || bus_if.rdata !== 8'h01)
         $display("FAIL stp_on_tc: got done=%b count=%h expected done=0 count=01", bus_if.done, bus_if.rdata);
      else n_pass++;
      cmd(4'h5, 8'h02);
      n_checks++;
      if (bus_if.rdata !== 8'h00) $display("FAIL stp_on_tc_status: got %h expected 00", bus_if.rdata);
      else n_pass++;
      cmd(4'h2, 8'h00);
      idle(P - 1);
      cmd(4'h4, 8'h00);
      n_checks++;
      if (bus_if.done !== 1'b1 || bus_if.rdata !== (AR ? 8'h03 : 8'h01))
         $display("FAIL ack_on_tc: got done=%b status=%h expected done=1 status=%h",
                  bus_if.done, bus_if.rdata, AR ? 8'h03 : 8'h01);
      else n_pass++;
      cmd(4'h3, 8'h00);
      cmd(4'h4, 8'h00);
   endtask

   task automatic test_err_readback();
      cmd(4'hB, 8'h00);
      cmd(4'h5, 8'h02);
      n_checks++;
      if (bus_if.rdata !== 8'h80) $display("FAIL err_status: got %h expected 80", bus_if.rdata);
      else n_pass++;
      cmd(4'h5, 8'h03);
      n_checks++;
      if (bus_if.rdata !== 8'hA5) $display("FAIL timer_id: got %h expected a5", bus_if.rdata);
      else n_pass++;
      cmd(4'h5, 8'h02);
      cmd(4'h1, 8'h04);
      cyc(1'b0, 12'h200);
      idle(3);
      n_checks++;
      if (bus_if.rdata !== 8'h80 || bus_if.done !== 1'b0)
         $display("FAIL en_low_str: got status=%h done=%b expected status=80 done=0", bus_if.rdata, bus_if.done);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0]  exp_r;
      logic [11:0] w;
      logic        en;
      int          r;
      apply_reset(1);
      for (int i = 0; i < 800; i++) begin
         en = ($urandom_range(0, 9) < 3);
         r  = $urandom_range(0, 39);
         if (r < 8)       w = {4'h1, 8'($urandom_range(0, 5))};
         else if (r < 14) w = {4'h2, 8'($urandom)};
         else if (r < 18) w = {4'h3, 8'($urandom)};
         else if (r < 24) w = {4'h4, 8'($urandom)};
         else if (r < 32) w = {4'h5, 8'($urandom)};
         else if (r < 38) w = {4'h0, 8'($urandom)};
         else             w = {4'($urandom_range(6, 15)), 8'($urandom)};
         cyc(en, w);
         exp_r = m_rdata();
         n_checks++;
         if (bus_if.rdata !== exp_r)
            $display("FAIL rand_rdata[%0d]: got %h expected %h", i, bus_if.rdata, exp_r);
         else n_pass++;
         n_checks++;
         if (bus_if.done !== m_done)
            $display("FAIL rand_done[%0d]: got %b expected %b", i, bus_if.done, m_done);
         else n_pass++;
      end
   endtask

`ifdef SEQ_TIMER_AUTORELOAD_EN
   task automatic test_autoreload();
      apply_reset(1);
      cmd(4'h1, 8'h02);
      cmd(4'h2, 8'h00);
      idle(2 * P - 1);
      n_checks++;
      if (bus_if.done !== 1'b0) $display("FAIL ar_early_done: got %b expected 0", bus_if.done);
      else n_pass++;
      idle(1);
      n_checks++;
      if (bus_if.done !== 1'b1 || bus_if.rdata !== 8'h02)
         $display("FAIL ar_reload: got done=%b count=%h expected done=1 count=02", bus_if.done, bus_if.rdata);
      else n_pass++;
      idle(P);
      n_checks++;
      if (bus_if.rdata !== 8'h01) $display("FAIL ar_count1: got %h expected 01", bus_if.rdata);
      else n_pass++;
      idle(P);
      n_checks++;
      if (bus_if.rdata !== 8'h02 || bus_if.done !== 1'b1)
         $display("FAIL ar_count2: got count=%h done=%b expected count=02 done=1", bus_if.rdata, bus_if.done);
      else n_pass++;
      cmd(4'h5, 8'h02);
      n_checks++;
      if (bus_if.rdata !== 8'h03) $display("FAIL ar_status: got %h expected 03", bus_if.rdata);
      else n_pass++;
   endtask
`endif

   initial begin
      reset           = 1'b1;
      bus_if.cmd_en   = 1'b0;
      bus_if.cmd_word = 12'h000;
      model_reset();
      apply_reset(2);
      test_reset();
      test_basic_run();
      test_stop_boundary();
      test_simultaneous();
      test_err_readback();
      test_random();
`ifdef SEQ_TIMER_AUTORELOAD_EN
      test_autoreload();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
